// File: rtl/md_stall_ctrl.sv
// HI/LO unit busy tracker and pipeline stall merger: sole source of pc_en, d_en and e_flush.
// Define MD_STALL_COUNT_EN to build the 32-bit stall cycle counter on stall_count.
module md_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic        e_is_div,
    input  logic        d_is_md,
    input  logic        data_stall_req,
    output logic        pc_en,
    output logic        d_en,
    output logic        e_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [4:0]  busy_cnt,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_e;

    localparam logic [4:0] MULT_LD = MULT_CYCLES[4:0];
    localparam logic [4:0] DIV_LD  = DIV_CYCLES[4:0];

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start while busy is ignored; the stall keeps a second HI/LO op out of E.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (e_start) begin
                    state_d = e_is_div ? DIV : MULT;
                    cnt_d   = e_is_div ? DIV_LD : MULT_LD;
                end
            end
            MULT, DIV: begin
                if (cnt_q <= 5'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        md_busy  = (state_q != IDLE);
        md_done  = md_busy && (cnt_q == 5'd1);
        busy_cnt = cnt_q;
        stall    = data_stall_req | (d_is_md & (e_start | md_busy));
        pc_en    = ~stall;
        d_en     = ~stall;
        e_flush  = stall;
    end

`ifdef MD_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: doc/md_stall_ctrl.md
# md_stall_ctrl

Pipeline stall controller for the multiply/divide (HI/LO) unit of the five-stage CPU. It tracks how many cycles the HI/LO unit has left on the current operation and freezes the PC and the D-stage pipeline register while an instruction in D needs HI/LO before the unit is ready. While stalled it inserts a bubble into E. It also merges the existing data-hazard stall request, so it is the single source of `pc_en`, `d_en` and `e_flush` for the pipeline.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu; legal range 1..31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1..31.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `e_start`  in  1  the E-stage instruction is mult/multu/div/divu and launches this cycle.
- `e_is_div`  in  1  qualifies `e_start`: 1 = div/divu, 0 = mult/multu.
- `d_is_md`  in  1  the D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- `data_stall_req`  in  1  register-use hazard stall request from the forwarding unit.
- `pc_en`  out  1  PC write enable.
- `d_en`  out  1  D-stage register load enable.
- `e_flush`  out  1  clear the E-stage register (insert a nop).
- `md_busy`  out  1  the HI/LO unit is mid-operation.
- `md_done`  out  1  last busy cycle of the current operation.
- `busy_cnt`  out  5  remaining busy cycles.
- `stall_count`  out  32  total stall cycles (see Configuration).

## Operation
States:
- IDLE: `busy_cnt`=0.
- MULT: operation in progress for mult/multu.
- DIV: operation in progress for div/divu.

Transitions:
- IDLE with `e_start`=1: go to DIV if `e_is_div`=1, else MULT. `busy_cnt` loads `DIV_CYCLES` or `MULT_CYCLES` respectively.
- MULT/DIV: `busy_cnt` decrements by 1 each cycle. On the edge where `busy_cnt`=1, go to IDLE and set `busy_cnt`=0.
- `e_start` in MULT/DIV is ignored: no reload and no state change. This cannot occur in correct operation, because the stall blocks a second HI/LO instruction from reaching E.

Outputs:
- `md_busy` = (state != IDLE).
- `md_done` = `md_busy` & (`busy_cnt`=1).
- Internal `stall` = `data_stall_req` | (`d_is_md` & (`e_start` | `md_busy`)).
- `pc_en` = `d_en` = ~`stall`.
- `e_flush` = `stall`.
- Arithmetic: `busy_cnt` is unsigned 5-bit and never wraps, because a decrement only happens when `busy_cnt` ≥ 1.

## Timing
- Reset values after the reset edge:
  - state IDLE, `busy_cnt`=0, `md_busy`=0, `md_done`=0, `stall_count`=0.
  - `pc_en`/`d_en`/`e_flush` are combinational: with all inputs at 0 they read 1/1/0.
- Reset mid-operation: the unit returns to IDLE on that edge and the pending operation is abandoned.
- Reset has priority over `e_start` on the same edge.
- `e_start` is sampled in cycle t. `md_busy`=1 in cycles t+1..t+N (N = `MULT_CYCLES` or `DIV_CYCLES`), and `md_done`=1 in cycle t+N.
- Stall latency:
  - Combinational, same cycle.
  - A HI/LO instruction in D is held from cycle t through t+N and advances to E on the edge ending cycle t+N+1, the first cycle with `md_busy`=0 and `e_start`=0.
  - A back-to-back mult/div pair therefore incurs N+1 stall cycles on the second instruction.
- A new `e_start` may arrive in the first IDLE cycle (t+N+1).
- `data_stall_req` and the HI/LO stall asserting together count as one stall cycle.

## Configuration
- Macro: `MD_STALL_COUNT_EN`.
- With the macro defined:
  - `stall_count` is a 32-bit register, cleared by reset, that increments on every edge where `stall`=1.
  - It wraps from 0xFFFFFFFF to 0.
- Without the macro: no counter register is built and `stall_count` is tied to 0.

## Test plan
- Reset with `e_start`=1 asserted during reset → after reset: `md_busy`=0, `busy_cnt`=0, `pc_en`=1, `e_flush`=0, `stall_count`=0.
- mult start (`e_start`=1, `e_is_div`=0) in cycle 0, `d_is_md`=0 → `md_busy`=1 in cycles 1..5, `busy_cnt` reads 5,4,3,2,1, `md_done`=1 only in cycle 5, and no stall.
- div start in cycle 0 with mflo in D (`d_is_md`=1 held) → `pc_en`=`d_en`=0 and `e_flush`=1 in cycles 0..10, released in cycle 11. With `MD_STALL_COUNT_EN`, `stall_count`=11.
- `e_start`=1 during cycle 3 of a mult → ignored: `busy_cnt` keeps decrementing and the unit reaches IDLE in cycle 6.
- `reset` pulsed in cycle 4 of a div → cycle 5 has `md_busy`=0 and `busy_cnt`=0. A new mult started in cycle 5 runs a full 5 busy cycles.
- `data_stall_req`=1 in cycle 2 with `d_is_md`=0 and the unit idle → stall only in cycle 2. `data_stall_req` overlapping a HI/LO stall → one count per cycle.
